// File: rtl/seq_pattern_detector_pkg.sv
// Shared encodings and default sizes for the serial pattern detector and its helpers.
// Pure declarations; no logic, no latency.
package seq_pattern_detector_pkg;

   typedef enum logic {
      MODE_MEALY = 1'b0,
      MODE_MOORE = 1'b1
   } mode_e;

   typedef enum logic {
      OVL_OFF = 1'b0,
      OVL_ON  = 1'b1
   } ovl_e;

   localparam int DEF_LEN   = 4;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update, clear beats increment.
// No backpressure: increments are taken whenever en is high and the count is not at all-ones.
module sat_counter #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         sat
);

   logic [W-1:0] value_q, value_d;

   assign sat   = &value_q;
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (en && !sat) begin
         value_d = value_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial LEN-bit pattern detector with programmable pattern, Mealy (0-cycle) or Moore (1-cycle) z.
// No backpressure: en qualifies each bit, load discards the bit of its cycle.
module seq_pattern_detector
   import seq_pattern_detector_pkg::*;
#(
   parameter int             LEN         = DEF_LEN,
   parameter logic [LEN-1:0] DEF_PATTERN = LEN'(4'b1011),
   parameter int             CNT_W       = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             w,
   input  logic             load,
   input  logic [LEN-1:0]   pat_in,
   input  logic             moore,
   input  logic             overlap,
   input  logic             clr_count,
   output logic             z,
   output logic [CNT_W-1:0] hit_count,
   output logic             count_sat
);

   localparam int                FILL_W   = $clog2(LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

   logic [LEN-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [LEN-1:0]  pat_q, pat_d;
   logic            z_q, z_d;
   logic            accept;
   logic            match_now;
   logic [LEN-1:0]  window;

   // The window is the stored history plus the bit arriving now, newest in bit 0.
   assign accept    = en & ~load;
   assign window    = {hist_q, w};
   assign match_now = accept & (fill_q == FILL_MAX) & (window == pat_q);

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      z_d    = match_now;
      if (load) begin
         pat_d  = pat_in;
         fill_d = '0;
      end else if (en) begin
         hist_d = window[LEN-2:0];
         if (match_now && (ovl_e'(overlap) == OVL_OFF)) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= DEF_PATTERN;
         z_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         z_q    <= z_d;
      end
   end

   // fill is zero throughout reset, so the Mealy path is also quiet then.
   assign z = (mode_e'(moore) == MODE_MOORE) ? z_q : match_now;

   sat_counter #(.W(CNT_W)) u_hits (
      .clk   (clk),
      .reset (reset),
      .en    (match_now),
      .clr   (clr_count),
      .value (hit_count),
      .sat   (count_sat)
   );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios with literal expectations, then random traffic
// compared each cycle against a queue-based model of the accepted bit stream.
module tb_seq_pattern_detector;

   localparam int LEN = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           en = 1'b0, w = 1'b0, load = 1'b0, moore = 1'b0, overlap = 1'b1, clr_count = 1'b0;
   logic [LEN-1:0] pat_in = '0;
   logic           z_a, z_b, sat_a, sat_b;
   logic [7:0]     hc_a;
   logic [1:0]     hc_b;

   int tests = 0;
   int fails = 0;

   // Model: bits accepted since the last restart (reset, load, non-overlap match), oldest first.
   bit             mq[$];
   logic [LEN-1:0] m_pat = 4'b1011;
   bit             m_zq = 1'b0;
   int             m_cnt_a = 0, m_cnt_b = 0;

   always #5 clk = ~clk;

   seq_pattern_detector #(.LEN(LEN), .DEF_PATTERN(4'b1011), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .en(en), .w(w), .load(load), .pat_in(pat_in),
      .moore(moore), .overlap(overlap), .clr_count(clr_count),
      .z(z_a), .hit_count(hc_a), .count_sat(sat_a)
   );

   seq_pattern_detector #(.LEN(LEN), .DEF_PATTERN(4'b1011), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .en(en), .w(w), .load(load), .pat_in(pat_in),
      .moore(moore), .overlap(overlap), .clr_count(clr_count),
      .z(z_b), .hit_count(hc_b), .count_sat(sat_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_match(input bit wb);
      if (mq.size() < LEN - 1) return 1'b0;
      if (wb != m_pat[0]) return 1'b0;
      for (int i = 1; i < LEN; i++)
         if (mq[mq.size() - i] != m_pat[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_outputs(input bit exp_z);
      check("z_a", 32'(z_a), 32'(exp_z));
      check("z_b", 32'(z_b), 32'(exp_z));
      check("hit_count_a", 32'(hc_a), m_cnt_a);
      check("hit_count_b", 32'(hc_b), m_cnt_b);
      check("count_sat_a", 32'(sat_a), 32'(m_cnt_a == 255));
      check("count_sat_b", 32'(sat_b), 32'(m_cnt_b == 3));
   endtask

   // Called just after a falling edge; drives one cycle, checks, then advances the model.
   task automatic step(input bit e, input bit wb, input bit ld, input logic [LEN-1:0] pin,
                       input bit mo, input bit ov, input bit cl, input int exp_z);
      bit mt;
      en = e; w = wb; load = ld; pat_in = pin; moore = mo; overlap = ov; clr_count = cl;
      #1;
      mt = e && !ld && m_match(wb);
      check_outputs(mo ? m_zq : mt);
      if (exp_z >= 0) check("z_literal", 32'(z_a), exp_z);
      @(posedge clk);
      if (ld) begin
         m_pat = pin;
         mq.delete();
      end else if (e) begin
         if (mt && !ov) mq.delete();
         else begin
            mq.push_back(wb);
            if (mq.size() > LEN - 1) void'(mq.pop_front());
         end
      end
      m_zq = mt;
      if (cl) begin
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else if (mt) begin
         if (m_cnt_a < 255) m_cnt_a++;
         if (m_cnt_b < 3) m_cnt_b++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("reset_z_a", 32'(z_a), 0);
      check("reset_z_b", 32'(z_b), 0);
      check("reset_hits_a", 32'(hc_a), 0);
      check("reset_sat_b", 32'(sat_b), 0);
      mq.delete();
      m_pat = 4'b1011;
      m_zq = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [6:0]  s7;
      logic [6:0]  e7;
      logic [15:0] s16;
      bit          mo, ov;

      @(negedge clk);
      do_reset();

      // Scenario 1: Mealy with overlap, hits on bits 4 and 7.
      s7 = 7'b1011011; e7 = 7'b0001001;
      for (int i = 6; i >= 0; i--) step(1'b1, s7[i], 1'b0, '0, 1'b0, 1'b1, 1'b0, int'(e7[i]));
      check("t1_hits", 32'(hc_a), 2);

      // Scenario 2: no overlap, only the first hit.
      do_reset();
      e7 = 7'b0001000;
      for (int i = 6; i >= 0; i--) step(1'b1, s7[i], 1'b0, '0, 1'b0, 1'b0, 1'b0, int'(e7[i]));
      check("t2_hits", 32'(hc_a), 1);

      // Scenario 3: Moore, one-cycle-delayed single-cycle pulses.
      do_reset();
      e7 = 7'b0000100;
      for (int i = 6; i >= 0; i--) step(1'b1, s7[i], 1'b0, '0, 1'b1, 1'b1, 1'b0, int'(e7[i]));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 0);

      // Scenario 4: idle cycles between bits are invisible.
      do_reset();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1);

      // Scenario 5: load drops history and its own bit.
      do_reset();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1);

      // Scenario 6: five hits saturate the 2-bit counter; clear beats a simultaneous hit.
      do_reset();
      s16 = 16'b1011011011011011;
      for (int i = 15; i >= 0; i--) step(1'b1, s16[i], 1'b0, '0, 1'b0, 1'b1, 1'b0, -1);
      check("t6_hits_b", 32'(hc_b), 3);
      check("t6_sat_b", 32'(sat_b), 1);
      check("t6_hits_a", 32'(hc_a), 5);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1);
      check("t6_clr_b", 32'(hc_b), 0);
      check("t6_clr_sat", 32'(sat_b), 0);

      // Scenario 7: reset mid-stream restores the default pattern and drops history.
      step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, (i == 3) ? 1 : 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      do_reset();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1);

      // Random traffic with mode flips, loads, clears and occasional resets.
      mo = 1'b0;
      ov = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         if ($urandom_range(0, 31) == 0) mo = ~mo;
         if ($urandom_range(0, 31) == 0) ov = ~ov;
         step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
              4'($urandom), mo, ov, $urandom_range(0, 99) == 0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
